// File: rtl/demux_1_to_8_deser.sv
// Serial-to-parallel deserializer: rebuilds a word sent LSB first (select 0..N-1) on a 1-bit stream.
// Latency: o_valid rises 1 cycle after the last bit of a frame is accepted.
// Backpressure: one-word output register; a word completing while o_valid && !i_ready is dropped (o_overrun).
module demux_1_to_8_deser #(
    parameter  int DATA_WIDTH = 8,
    localparam int IDX_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_bit,
    input  logic                  i_bit_valid,
    input  logic                  i_start,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic [IDX_W-1:0]      o_bit_idx,
    output logic                  o_overrun,
    output logic                  o_resync,
    input  logic                  i_clr_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Index of the final bit of a frame; reaching it closes the frame.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  valid_q;
    logic                  valid_d;
    logic                  overrun_q;
    logic                  resync_q;

    logic                  frame_done;
    logic [DATA_WIDTH-1:0] word;
    logic                  overrun_set;
    logic                  resync_set;

    // The final bit goes straight into the word; it never needs to land in the shift register.
    assign word = {i_bit, shift_q[DATA_WIDTH-2:0]};

    // Frame assembly: next state, shift register contents and write index.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        frame_done = 1'b0;
        resync_set = 1'b0;
        case (state_q)
            IDLE: begin
                // Bits arriving without a start marker are not part of any frame.
                if (i_bit_valid && i_start) begin
                    shift_d[0] = i_bit;
                    idx_d      = IDX_W'(1);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (i_bit_valid) begin
                    if (i_start) begin
                        // Start marker inside a frame: drop the partial word and restart.
                        resync_set = 1'b1;
                        shift_d    = '0;
                        shift_d[0] = i_bit;
                        idx_d      = IDX_W'(1);
                    end else begin
                        shift_d[idx_q] = i_bit;
                        if (idx_q == LAST_IDX) begin
                            idx_d      = '0;
                            frame_done = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Output register: load a completed word if the slot is free or being drained, else drop it.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_set = 1'b0;
        if (frame_done) begin
            if (!valid_q || i_ready) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift register and write index.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    // Output word and its valid flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Sticky error flags; a set in the same cycle as a clear takes priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overrun_q <= 1'b0;
            resync_q  <= 1'b0;
        end else begin
            overrun_q <= overrun_set | (overrun_q & ~i_clr_err);
            resync_q  <= resync_set  | (resync_q  & ~i_clr_err);
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_busy    = (state_q == SHIFT);
    assign o_bit_idx = idx_q;
    assign o_overrun = overrun_q;
    assign o_resync  = resync_q;

endmodule

// File: tb/tb_demux_1_to_8_deser.sv
// Bench for the 1-to-8 deserializer: directed scenarios followed by random traffic.
// Every step is checked one time unit after the rising edge against a frame-level model.
// Model tracks bits collected so far, the pending output word and the sticky flags.
module tb_demux_1_to_8_deser;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_bit;
    logic       i_bit_valid;
    logic       i_start;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_busy;
    logic [2:0] o_bit_idx;
    logic       o_overrun;
    logic       o_resync;
    logic       i_clr_err;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    int         m_cnt;      // bits of the current frame received so far (0 = no frame)
    logic [7:0] m_word;     // bits of the current frame, LSB first
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ovr;
    logic       m_rsy;

    demux_1_to_8_deser #(.DATA_WIDTH(8)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_bit       (i_bit),
        .i_bit_valid (i_bit_valid),
        .i_start     (i_start),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_bit_idx   (o_bit_idx),
        .o_overrun   (o_overrun),
        .o_resync    (o_resync),
        .i_clr_err   (i_clr_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_word  = '0;
        m_data  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_rsy   = 1'b0;
    endtask

    task automatic check_all(input string where);
        chk({where, " o_data"},    32'(o_data),    32'(m_data));
        chk({where, " o_valid"},   32'(o_valid),   32'(m_valid));
        chk({where, " o_busy"},    32'(o_busy),    32'(m_cnt != 0));
        chk({where, " o_bit_idx"}, 32'(o_bit_idx), 32'(m_cnt));
        chk({where, " o_overrun"}, 32'(o_overrun), 32'(m_ovr));
        chk({where, " o_resync"},  32'(o_resync),  32'(m_rsy));
    endtask

    // Model reaction to one clock edge with the given inputs.
    task automatic model_edge(input logic bv, input logic st, input logic b,
                              input logic rdy, input logic clr);
        logic       done;
        logic       ovr_set;
        logic       rsy_set;
        logic [7:0] w;
        done    = 1'b0;
        ovr_set = 1'b0;
        rsy_set = 1'b0;
        w       = '0;
        if (bv) begin
            if (st) begin
                if (m_cnt != 0) rsy_set = 1'b1;
                m_word    = '0;
                m_word[0] = b;
                m_cnt     = 1;
            end else if (m_cnt != 0) begin
                m_word[m_cnt] = b;
                m_cnt++;
                if (m_cnt == 8) begin
                    done  = 1'b1;
                    w     = m_word;
                    m_cnt = 0;
                end
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_data  = w;
                m_valid = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        m_ovr = ovr_set | (m_ovr & ~clr);
        m_rsy = rsy_set | (m_rsy & ~clr);
    endtask

    // Drive one cycle of inputs, let the edge happen, update the model, check.
    task automatic step(input logic bv, input logic st, input logic b,
                        input logic rdy, input logic clr);
        i_bit_valid = bv;
        i_start     = st;
        i_bit       = b;
        i_ready     = rdy;
        i_clr_err   = clr;
        @(posedge i_clk);
        model_edge(bv, st, b, rdy, clr);
        #1;
        check_all("step");
    endtask

    // Send a full frame LSB first; optional idle gap after bit gap_at. Returns cycles with o_busy high.
    task automatic send_frame(input logic [7:0] w, input int gap_at, input int gap_len,
                              input logic rdy, output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i == 0, w[i], rdy, 1'b0);
            if (o_busy) busy_cnt++;
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    step(1'b0, 1'b0, 1'($urandom), rdy, 1'b0);
                    if (o_busy) busy_cnt++;
                end
            end
        end
    endtask

    initial begin
        int         busy;
        logic [7:0] w;

        i_rst_n     = 1'b0;
        i_bit       = 1'b0;
        i_bit_valid = 1'b0;
        i_start     = 1'b0;
        i_ready     = 1'b0;
        i_clr_err   = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // 1: basic frame, back-to-back bits
        send_frame(8'hCA, -1, 0, 1'b1, busy);
        chk("t1 busy cycles", 32'(busy), 32'd7);
        chk("t1 data", 32'(o_data), 32'hCA);
        chk("t1 valid", 32'(o_valid), 32'd1);

        // 2: same frame with a 3-cycle gap after bit 4
        send_frame(8'hCA, 4, 3, 1'b1, busy);
        chk("t2 busy cycles", 32'(busy), 32'd10);
        chk("t2 data", 32'(o_data), 32'hCA);
        chk("t2 valid", 32'(o_valid), 32'd1);

        // 3: backpressure and overrun, then drain and clear
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hCA, -1, 0, 1'b0, busy);
        send_frame(8'h35, -1, 0, 1'b0, busy);
        chk("t3 data held", 32'(o_data), 32'hCA);
        chk("t3 valid held", 32'(o_valid), 32'd1);
        chk("t3 overrun", 32'(o_overrun), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3 drained", 32'(o_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3 overrun clr", 32'(o_overrun), 32'd0);

        // 4: partial frame interrupted by a new start
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'($urandom), 1'b1, 1'b0);
        send_frame(8'hA5, -1, 0, 1'b1, busy);
        chk("t4 resync", 32'(o_resync), 32'd1);
        chk("t4 data", 32'(o_data), 32'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t4 resync clr", 32'(o_resync), 32'd0);

        // 5: bits without a start marker in IDLE are ignored
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'($urandom), 1'b1, 1'b0);
        chk("t5 busy", 32'(o_busy), 32'd0);
        chk("t5 valid", 32'(o_valid), 32'd0);

        // 6: reset mid-frame, then a full frame
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        i_rst_n = 1'b0;
        model_reset();
        #1;
        check_all("t6 in reset");
        chk("t6 busy", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        send_frame(8'hFF, -1, 0, 1'b1, busy);
        chk("t6 data", 32'(o_data), 32'hFF);

        // Random traffic: gaps, restarts, backpressure and flag clears
        for (int f = 0; f < 40; f++) begin
            w = 8'($urandom);
            send_frame(w, int'($urandom_range(0, 9)), int'($urandom_range(0, 2)), 1'b1, busy);
            chk("rnd frame data", 32'(o_data), 32'(w));
        end
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, 1'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
